// File: rtl/rf_pkg.sv
// Shared defaults and address-decode helper for the register file and its scoreboard.
package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_NREAD  = 2;

    // Bit idx of the one-hot mask produced by decoding addr, gated by en.
    // Callers build a full mask by iterating idx over the register depth.
    function automatic logic rf_wmask_bit(input logic en, input int unsigned addr,
                                          input int unsigned idx);
        return en && (addr == idx);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-bit array for the register file: claims set a bit, writebacks clear it,
// and a same-cycle claim overrides the clear because the new producer is still in flight.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NREAD    = RF_NREAD,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    input  logic                    we0,
    input  logic [ADDR_W-1:0]       wa0,
    input  logic                    we1,
    input  logic [ADDR_W-1:0]       wa1,
    input  logic                    claim_en,
    input  logic [ADDR_W-1:0]       claim_addr,
    output logic [NREAD-1:0]        rd_busy,
    output logic                    claim_hit
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;
    logic [DEPTH-1:0] set_mask;
    logic [DEPTH-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            set_mask[i] = rf_wmask_bit(claim_en, 32'(claim_addr), i);
            clr_mask[i] = rf_wmask_bit(we0, 32'(wa0), i) | rf_wmask_bit(we1, 32'(wa1), i);
        end
        // Set after clear: a claim racing a writeback leaves the bit pending.
        pending_d = (pending_q & ~clr_mask) | set_mask;
        if (ZERO_REG) begin
            pending_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_busy
        logic [ADDR_W-1:0] addr;
        logic              written;
        assign addr    = rd_addr[k*ADDR_W +: ADDR_W];
        assign written = (we0 && (wa0 == addr)) || (we1 && (wa1 == addr));
        assign rd_busy[k] = pending_q[addr] & ~written & ~(ZERO_REG && (addr == '0));
    end

    logic claim_written;
    assign claim_written = (we0 && (wa0 == claim_addr)) || (we1 && (wa1 == claim_addr));
    assign claim_hit = pending_q[claim_addr] & ~claim_written
                       & ~(ZERO_REG && (claim_addr == '0));

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with two writeback ports, write-through forwarding,
// optional hardwired zero register and a pending-write scoreboard.
module regfile_sb
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NREAD    = RF_NREAD,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    output logic [NREAD*DATA_W-1:0] rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic                    we0,
    input  logic [ADDR_W-1:0]       wa0,
    input  logic [DATA_W-1:0]       wd0,
    input  logic                    we1,
    input  logic [ADDR_W-1:0]       wa1,
    input  logic [DATA_W-1:0]       wd1,
    input  logic                    claim_en,
    input  logic [ADDR_W-1:0]       claim_addr,
    output logic                    claim_hit
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (rf_wmask_bit(we0, 32'(wa0), i)) begin
                mem_d[i] = wd0;
            end
            // Port 1 (LSU) is applied last so it wins an address collision.
            if (rf_wmask_bit(we1, 32'(wa1), i)) begin
                mem_d[i] = wd1;
            end
        end
        if (ZERO_REG) begin
            mem_d[0] = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;

        assign addr = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            data = mem_q[addr];
            if (we0 && (wa0 == addr)) begin
                data = wd0;
            end
            if (we1 && (wa1 == addr)) begin
                data = wd1;
            end
            if (ZERO_REG && (addr == '0)) begin
                data = '0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = data;
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NREAD    (NREAD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .we0        (we0),
        .wa0        (wa0),
        .we1        (we1),
        .wa1        (wa1),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .rd_busy    (rd_busy),
        .claim_hit  (claim_hit)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, hand-written reset/parameter sequences,
// and randomized traffic checked against an array-based reference model.
module tb_regfile_sb;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- default instance (ZERO_REG=1) ----------------
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        we0, we1, claim_en, claim_hit;
    logic [4:0]  wa0, wa1, claim_addr;
    logic [31:0] wd0, wd1;

    regfile_sb dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .we0        (we0),
        .wa0        (wa0),
        .wd0        (wd0),
        .we1        (we1),
        .wa1        (wa1),
        .wd1        (wd1),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .claim_hit  (claim_hit)
    );

    // ---------------- swept instance (NREAD=4, ADDR_W=3, ZERO_REG=0) ----------------
    logic [11:0]  p_rd_addr;
    logic [127:0] p_rd_data;
    logic [3:0]   p_rd_busy;
    logic         p_we0, p_we1, p_claim_en, p_claim_hit;
    logic [2:0]   p_wa0, p_wa1, p_claim_addr;
    logic [31:0]  p_wd0, p_wd1;

    regfile_sb #(
        .DATA_W   (32),
        .ADDR_W   (3),
        .NREAD    (4),
        .ZERO_REG (1'b0)
    ) dut_p (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (p_rd_addr),
        .rd_data    (p_rd_data),
        .rd_busy    (p_rd_busy),
        .we0        (p_we0),
        .wa0        (p_wa0),
        .wd0        (p_wd0),
        .we1        (p_we1),
        .wa1        (p_wa1),
        .wd1        (p_wd1),
        .claim_en   (p_claim_en),
        .claim_addr (p_claim_addr),
        .claim_hit  (p_claim_hit)
    );

    // ---------------- counters / scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        rd_addr = '0; we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0; claim_en = 1'b0; claim_addr = '0;
        p_rd_addr = '0; p_we0 = 1'b0; p_wa0 = '0; p_wd0 = '0;
        p_we1 = 1'b0; p_wa1 = '0; p_wd1 = '0; p_claim_en = 1'b0; p_claim_addr = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        cl;
        logic [4:0]  ca;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
        logic [1:0]  e_b;
        logic        e_hit;
    } vec_t;

    function automatic vec_t mk(input logic w0, input int a0, input logic [31:0] d0,
                                input logic w1, input int a1, input logic [31:0] d1,
                                input logic cl, input int ca, input int r0, input int r1,
                                input logic [31:0] ed0, input logic [31:0] ed1,
                                input int eb, input logic eh);
        vec_t v;
        v.we0 = w0; v.wa0 = 5'(a0); v.wd0 = d0;
        v.we1 = w1; v.wa1 = 5'(a1); v.wd1 = d1;
        v.cl = cl; v.ca = 5'(ca); v.ra0 = 5'(r0); v.ra1 = 5'(r1);
        v.e_d0 = ed0; v.e_d1 = ed1; v.e_b = 2'(eb); v.e_hit = eh;
        return v;
    endfunction

    task automatic apply_vec(input vec_t v);
        we0 = v.we0; wa0 = v.wa0; wd0 = v.wd0;
        we1 = v.we1; wa1 = v.wa1; wd1 = v.wd1;
        claim_en = v.cl; claim_addr = v.ca;
        rd_addr = {v.ra1, v.ra0};
    endtask

    localparam int NV = 17;
    vec_t vecs[NV];

    // ---------------- reference model ----------------
    logic [31:0] m_reg [32];
    bit          m_pend [32];

    function automatic logic [31:0] m_read(input int a);
        if (a == 0) return 32'h0;
        if (we1 && int'(wa1) == a) return wd1;
        if (we0 && int'(wa0) == a) return wd0;
        return m_reg[a];
    endfunction

    function automatic logic m_busy(input int a);
        if (a == 0) return 1'b0;
        if ((we0 && int'(wa0) == a) || (we1 && int'(wa1) == a)) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic m_commit();
        if (we0 && wa0 != 0) begin m_reg[wa0] = wd0; m_pend[wa0] = 1'b0; end
        if (we1 && wa1 != 0) begin m_reg[wa1] = wd1; m_pend[wa1] = 1'b0; end
        if (claim_en && claim_addr != 0) m_pend[claim_addr] = 1'b1;
    endtask

    task automatic m_clear();
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vecs[0]  = mk(1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 0, 1, 2, 0, 0, 0, 1'b0);
        vecs[1]  = mk(1'b1, 3, 32'h11, 1'b1, 3, 32'h22, 1'b0, 0, 3, 3, 32'h22, 32'h22, 0, 1'b0);
        vecs[2]  = mk(1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 0, 3, 0, 32'h22, 0, 0, 1'b0);
        vecs[3]  = mk(1'b1, 0, 32'hFFFF_FFFF, 1'b0, 0, 0, 1'b1, 0, 0, 0, 0, 0, 0, 1'b0);
        vecs[4]  = mk(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 0, 0, 3, 0, 32'h22, 0, 1'b0);
        vecs[5]  = mk(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 9, 9, 0, 0, 0, 0, 1'b0);
        vecs[6]  = mk(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 9, 9, 9, 0, 0, 3, 1'b1);
        vecs[7]  = mk(1'b0, 0, 0, 1'b1, 9, 32'h1234, 1'b0, 0, 9, 3, 32'h1234, 32'h22, 0, 1'b0);
        vecs[8]  = mk(1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 0, 9, 9, 32'h1234, 32'h1234, 0, 1'b0);
        vecs[9]  = mk(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 4, 4, 9, 0, 32'h1234, 0, 1'b0);
        vecs[10] = mk(1'b1, 4, 32'h55, 1'b0, 0, 0, 1'b1, 4, 4, 9, 32'h55, 32'h1234, 0, 1'b0);
        vecs[11] = mk(1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 0, 4, 4, 32'h55, 32'h55, 3, 1'b0);
        vecs[12] = mk(1'b1, 4, 32'h66, 1'b1, 5, 32'h77, 1'b0, 0, 4, 5, 32'h66, 32'h77, 0, 1'b0);
        vecs[13] = mk(1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 0, 4, 5, 32'h66, 32'h77, 0, 1'b0);
        vecs[14] = mk(1'b1, 6, 32'hAB, 1'b0, 0, 0, 1'b0, 0, 6, 6, 32'hAB, 32'hAB, 0, 1'b0);
        vecs[15] = mk(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 6, 6, 4, 32'hAB, 32'h66, 0, 1'b0);
        vecs[16] = mk(1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 0, 6, 4, 32'hAB, 32'h66, 1, 1'b0);

        set_idle();
        reset = 1'b1;
        #2;
        check("reset rd_data", rd_data[31:0] | rd_data[63:32], 32'h0);
        check("reset rd_busy", 32'(rd_busy), 32'h0);
        check("reset claim_hit", 32'(claim_hit), 32'h0);
        #10;
        reset = 1'b0;

        // Directed table: state carries from one vector to the next.
        for (int i = 0; i < NV; i++) begin
            step();
            apply_vec(vecs[i]);
            #2;
            check($sformatf("v%0d rd0", i), rd_data[31:0], vecs[i].e_d0);
            check($sformatf("v%0d rd1", i), rd_data[63:32], vecs[i].e_d1);
            check($sformatf("v%0d busy", i), 32'(rd_busy), 32'(vecs[i].e_b));
            check($sformatf("v%0d hit", i), 32'(claim_hit), 32'(vecs[i].e_hit));
        end

        // Asynchronous reset in the middle of a cycle with a write and claim in flight.
        step();
        set_idle();
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF;
        claim_en = 1'b1; claim_addr = 5'd7;
        step();
        set_idle();
        we0 = 1'b1; wa0 = 5'd8; wd0 = 32'hCAFE_F00D;
        claim_en = 1'b1; claim_addr = 5'd7;
        rd_addr = {5'd7, 5'd5};
        #1;
        check("pre-reset r5", rd_data[31:0], 32'hDEAD_BEEF);
        check("pre-reset r7 busy", 32'(rd_busy[1]), 32'h1);
        check("pre-reset hit", 32'(claim_hit), 32'h1);
        reset = 1'b1;
        #1;
        check("mid-reset r5", rd_data[31:0], 32'h0);
        check("mid-reset busy", 32'(rd_busy), 32'h0);
        check("mid-reset hit", 32'(claim_hit), 32'h0);
        step();
        set_idle();
        reset = 1'b0;
        rd_addr = {5'd7, 5'd5};
        #2;
        check("post-reset r5", rd_data[31:0], 32'h0);
        check("post-reset r7 busy", 32'(rd_busy), 32'h0);
        rd_addr = {5'd7, 5'd8};
        #1;
        check("post-reset r8 dropped", rd_data[31:0], 32'h0);

        // Parameter sweep instance: address 0 is an ordinary register.
        step();
        set_idle();
        p_we0 = 1'b1; p_wa0 = 3'd0; p_wd0 = 32'hA5;
        #2;
        for (int k = 0; k < 4; k++)
            check($sformatf("p fwd r0 port%0d", k), p_rd_data[k*32 +: 32], 32'hA5);
        step();
        p_we0 = 1'b0;
        p_claim_en = 1'b1; p_claim_addr = 3'd0;
        #2;
        for (int k = 0; k < 4; k++)
            check($sformatf("p r0 port%0d", k), p_rd_data[k*32 +: 32], 32'hA5);
        check("p claim r0 hit", 32'(p_claim_hit), 32'h0);
        step();
        p_claim_en = 1'b0;
        #2;
        check("p r0 busy", 32'(p_rd_busy), 32'hF);
        check("p r0 hit", 32'(p_claim_hit), 32'h1);
        p_we1 = 1'b1; p_wa1 = 3'd0; p_wd1 = 32'h5A;
        #1;
        check("p r0 busy cleared", 32'(p_rd_busy), 32'h0);
        check("p r0 fwd port3", p_rd_data[127:96], 32'h5A);
        step();
        set_idle();

        // Randomized traffic against the model, starting from a clean reset.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        m_clear();
        for (int c = 0; c < 400; c++) begin
            step();
            we0 = 1'($urandom_range(0, 1)); wa0 = 5'($urandom_range(0, 7)); wd0 = $urandom;
            we1 = 1'($urandom_range(0, 1)); wa1 = 5'($urandom_range(0, 7)); wd1 = $urandom;
            claim_en = 1'($urandom_range(0, 1)); claim_addr = 5'($urandom_range(0, 7));
            rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            exp_q.push_back(m_read(int'(rd_addr[4:0])));
            exp_q.push_back(m_read(int'(rd_addr[9:5])));
            exp_q.push_back({30'h0, m_busy(int'(rd_addr[9:5])), m_busy(int'(rd_addr[4:0]))});
            exp_q.push_back({31'h0, (claim_addr != 0) && m_pend[claim_addr]
                             && !(we0 && wa0 == claim_addr) && !(we1 && wa1 == claim_addr)});
            #2;
            check($sformatf("rnd%0d rd0", c), rd_data[31:0], exp_q.pop_front());
            check($sformatf("rnd%0d rd1", c), rd_data[63:32], exp_q.pop_front());
            check($sformatf("rnd%0d busy", c), 32'(rd_busy), exp_q.pop_front());
            check($sformatf("rnd%0d hit", c), 32'(claim_hit), exp_q.pop_front());
            m_commit();
        end

        step();
        set_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port general-purpose register file with a pending-write scoreboard for the pipelined core. It provides NREAD combinational read ports, two write ports with write-through forwarding, and a hardwired zero register. Per-register pending bits let the issue stage detect read-after-write hazards on results still in flight. It sits between the decode/issue stage and the two writeback ports (ALU and load/store).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NREAD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes and claims

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- rd_addr  in  NREAD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NREAD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
- rd_busy  out  NREAD  1 = register on port k has an outstanding claim
- we0  in  1  write enable, port 0 (ALU writeback)
- wa0  in  ADDR_W  write address, port 0
- wd0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (LSU writeback)
- wa1  in  ADDR_W  write address, port 1
- wd1  in  DATA_W  write data, port 1
- claim_en  in  1  mark claim_addr as pending (destination issued)
- claim_addr  in  ADDR_W  register being claimed
- claim_hit  out  1  claim_addr is already pending (WAW indicator)

## Operation
- Storage: 2**ADDR_W x DATA_W registers plus 2**ADDR_W pending bits.
- Writes: on posedge clk, if weN, then reg[waN] <= wdN. If we0 and we1 target the same address, port 1 wins.
- Reads: combinational. Priority: ZERO_REG and address 0 gives 0; otherwise (we1 && wa1==addr) gives wd1; otherwise (we0 && wa0==addr) gives wd0; otherwise reg[addr].
- Pending set: claim_en sets pending[claim_addr] on posedge clk.
- Pending clear: a write on either port clears pending[waN] on posedge clk.
- Same-cycle claim and write to the same address: the claim wins and the bit stays 1 (the new producer is outstanding).
- rd_busy[k] = pending[addr_k] & ~(write to addr_k this cycle). It is 0 for address 0 when ZERO_REG=1.
- claim_hit = pending[claim_addr] & ~(write to claim_addr this cycle). It is informational only; the claim is still applied.
- ZERO_REG=1: writes and claims to address 0 are dropped. reg[0] and pending[0] stay 0.
- ZERO_REG=0: address 0 behaves like any other register.
- A write to a register that is not pending is legal. It updates the data and leaves pending at 0.

## Timing
- Reset (asynchronous): all registers become 0 and all pending bits become 0 immediately. Consequently rd_data = 0, rd_busy = 0, claim_hit = 0.
- Reset asserted mid-operation discards any in-flight write or claim in that cycle.
- Read latency is 0 cycles; forwarding makes a same-cycle write visible on rd_data.
- Write and claim latency is 1 cycle to storage and to the pending bits.
- No handshakes. All inputs are sampled only at posedge clk. Read paths are purely combinational from rd_addr, the write ports and state.

## Structure
- Package rf_pkg holds the defaults RF_DATA_W=32, RF_ADDR_W=5, RF_NREAD=2 and a function that decodes an address into a one-hot write mask.
- Sub-module rf_scoreboard holds the pending-bit array, the set/clear/priority logic, and generates rd_busy and claim_hit.
- The data array, write priority and forwarding muxes live in regfile_sb using a generate loop over NREAD.

## Test plan
- Reset: write 0xDEADBEEF to r5 and claim r7, then assert reset mid-cycle. Required: rd_data and rd_busy are 0 immediately, and r5 reads 0 after release.
- Forwarding and conflict: we0 writes 0x11 to r3 and we1 writes 0x22 to r3 in the same cycle, with read port 0 on r3. Required: rd_data shows 0x22 in that cycle and r3 holds 0x22 afterwards.
- Zero register: with ZERO_REG=1, write 0xFFFFFFFF to r0 and claim r0. Required: r0 reads 0, rd_busy=0, and claim_hit stays 0.
- Scoreboard lifecycle: claim r9, then check the next cycle. Required: rd_busy=1. Then write r9=0x1234 on port 1. Required: rd_busy=0 in the same cycle and data 0x1234 is forwarded.
- Claim/write collision: r4 is pending; claim r4 and write r4=0x55 on port 0 in the same cycle. Required: claim_hit=0, rd_busy=1 on the next cycle, and r4 reads 0x55.
- Parameter sweep: run with NREAD=4, ADDR_W=3 and ZERO_REG=0. Write r0=0xA5, then read all four ports on r0. Required: all four return 0xA5.
